// File: rtl/nmi_pkg.sv
// Shared NMI definitions: bus field widths, arbiter FSM states and the
// default error word returned when a slave never answers.
package nmi_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TERR = 2'd2
  } nmi_state_e;

endpackage

// File: rtl/nmi_arbiter_if.sv
// NMI bus bundle between NUM_MST masters, the arbiter and one slave.
//   m_valid/m_addr/m_wdata/m_wstrb : per-master request (wstrb 0 = read)
//   m_rdata/m_ready                : shared read data, per-master completion
//   s_valid/s_addr/s_wdata/s_wstrb : request towards the slave
//   s_rdata/s_ready                : slave response
// Modport slave is the arbiter's view; modport master is the requester/slave
// side that drives the arbiter.
interface nmi_arbiter_if #(
  parameter int unsigned NUM_MST = 3
);
  import nmi_pkg::*;

  logic [NUM_MST-1:0]             m_valid;
  logic [NUM_MST-1:0][ADDR_W-1:0] m_addr;
  logic [NUM_MST-1:0][DATA_W-1:0] m_wdata;
  logic [NUM_MST-1:0][STRB_W-1:0] m_wstrb;
  logic [DATA_W-1:0]              m_rdata;
  logic [NUM_MST-1:0]             m_ready;

  logic                           s_valid;
  logic [ADDR_W-1:0]              s_addr;
  logic [DATA_W-1:0]              s_wdata;
  logic [STRB_W-1:0]              s_wstrb;
  logic [DATA_W-1:0]              s_rdata;
  logic                           s_ready;

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
    output m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb
  );

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
    input  m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb
  );

endinterface

// File: rtl/nmi_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of req at or
// after ptr, wrapping modulo N.
//   req   : request vector
//   ptr   : highest-priority index
//   found : any request present
//   idx   : winning index (0 when nothing found)
module nmi_rr_pick #(
  parameter  int unsigned N  = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan from the farthest offset down so the closest requester wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      int c;
      c = int'(ptr) + i;
      if (c >= int'(N)) c = c - int'(N);
      if (req[IW'(c)]) begin
        found = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/nmi_arbiter.sv
// Round-robin arbiter sharing one NMI slave between NUM_MST masters, one
// transaction in flight, with a response watchdog.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : NMI bundle (masters in, slave out, responses back)
//   tmo_flag  : sticky timeout indication
//   tmo_addr  : address of the first timed-out request
//   tmo_clr   : clears tmo_flag/tmo_addr (a simultaneous timeout wins)
module nmi_arbiter import nmi_pkg::*; #(
  parameter int unsigned       NUM_MST  = 3,
  parameter int unsigned       TIMEOUT  = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  nmi_arbiter_if.slave      bus,
  output logic              tmo_flag,
  output logic [ADDR_W-1:0] tmo_addr,
  input  logic              tmo_clr
);

  localparam int unsigned IDX_W  = $clog2(NUM_MST);
  localparam int unsigned WCNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] BUSY = ST_BUSY;
  localparam logic [1:0] TERR = ST_TERR;

  logic [1:0]        state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [IDX_W-1:0]  gnt, gnt_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic              fresh;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  gnt_inc;
  logic              gnt_valid;
  logic              wd_hit;

  nmi_rr_pick #(.N(NUM_MST)) u_pick (
    .req   (bus.m_valid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign gnt_inc   = (gnt == IDX_W'(NUM_MST - 1)) ? '0 : IDX_W'(gnt + 1'b1);
  assign gnt_valid = bus.m_valid[gnt];

  // The first BUSY cycle only clears wcnt, so the error response lands
  // TIMEOUT+1 cycles after s_valid rises.
  assign wd_hit = (TIMEOUT != 0) && !fresh && (wcnt == WCNT_W'(TIMEOUT - 1));

  // Next-state logic and request/response muxes.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gnt_nxt     = gnt;
    bus.s_valid = 1'b0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.s_wstrb = '0;
    bus.m_ready = '0;
    bus.m_rdata = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          gnt_nxt   = pick_idx;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        bus.s_valid      = gnt_valid;
        bus.s_addr       = bus.m_addr[gnt];
        bus.s_wdata      = bus.m_wdata[gnt];
        bus.s_wstrb      = bus.m_wstrb[gnt];
        bus.m_ready[gnt] = bus.s_ready;
        if (gnt_valid) bus.m_rdata = bus.s_rdata;
        if (bus.s_ready) begin
          ptr_nxt   = gnt_inc;
          state_nxt = IDLE;
        end else if (!gnt_valid) begin
          // Master withdrew its request: abandon without a response.
          state_nxt = IDLE;
        end else if (wd_hit) begin
          state_nxt = TERR;
        end
      end
      TERR: begin
        bus.m_ready[gnt] = 1'b1;
        bus.m_rdata      = ERR_DATA;
        ptr_nxt          = gnt_inc;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer, grant and watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      wcnt  <= '0;
      fresh <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      fresh <= (state == IDLE) && (state_nxt == BUSY);
      if (state == BUSY) begin
        if (fresh)             wcnt <= '0;
        else if (!bus.s_ready) wcnt <= WCNT_W'(wcnt + 1'b1);
      end
    end
  end

  // Sticky timeout capture; only the first address is kept until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_flag <= 1'b0;
      tmo_addr <= '0;
    end else if (state == TERR) begin
      tmo_flag <= 1'b1;
      if (!tmo_flag || tmo_clr) tmo_addr <= bus.m_addr[gnt];
    end else if (tmo_clr) begin
      tmo_flag <= 1'b0;
      tmo_addr <= '0;
    end
  end

endmodule

// File: tb/tb_nmi_arbiter.sv
// Self-checking bench for nmi_arbiter: directed scenarios plus a randomized
// run checked against a round-robin reference model.
module tb_nmi_arbiter;
  import nmi_pkg::*;

  localparam int unsigned NM = 3;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tmo_flag;
  logic [31:0] tmo_addr;
  logic        tmo_clr;

  int total = 0;
  int bad   = 0;
  int exp_ptr = 0;

  nmi_arbiter_if #(.NUM_MST(NM)) bus ();

  nmi_arbiter #(
    .NUM_MST  (NM),
    .TIMEOUT  (TO),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .tmo_flag (tmo_flag),
    .tmo_addr (tmo_addr),
    .tmo_clr  (tmo_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: first requester at or after p, modulo NM.
  function automatic int rr_winner(input logic [NM-1:0] req, input int p);
    for (int k = 0; k < int'(NM); k++) begin
      int j;
      j = (p + k) % int'(NM);
      if (req[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [NM-1:0] onehot(input int w);
    logic [NM-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  // Single master m requests alone.
  task automatic issue(input int m, input logic [31:0] a, input logic [3:0] s);
    bus.m_valid    = '0;
    bus.m_valid[m] = 1'b1;
    bus.m_addr[m]  = a;
    bus.m_wdata[m] = $urandom;
    bus.m_wstrb[m] = s;
  endtask

  // Advance until any m_ready shows, bounded; c = -1 when the bound expires.
  task automatic wait_ready(output int c);
    c = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.m_ready !== '0) begin
        c = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tmo_clr = 1'b0;
    bus.m_valid = '0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_wstrb = '0;
    bus.s_rdata = 32'hA5A5_5A5A; bus.s_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    total++; if (bus.s_valid !== 1'b0) begin bad++; $display("FAIL rst_svalid: got %b want 0", bus.s_valid); end
    total++; if (bus.m_ready !== '0) begin bad++; $display("FAIL rst_mready: got %b want 0", bus.m_ready); end
    total++; if (bus.m_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus.m_rdata); end
    total++; if (tmo_flag !== 1'b0 || tmo_addr !== 32'h0) begin bad++; $display("FAIL rst_tmo: got %b/%h want 0/0", tmo_flag, tmo_addr); end
    exp_ptr = 0;
  endtask

  task automatic test_single_read();
    issue(1, 32'h1000, 4'h0);
    #1;
    total++; if (bus.s_valid !== 1'b0) begin bad++; $display("FAIL sr_no_comb: got %b want 0", bus.s_valid); end
    tick();
    bus.s_ready = 1'b1; bus.s_rdata = 32'h1234_5678;
    #1;
    total++; if (bus.s_valid !== 1'b1 || bus.s_addr !== 32'h1000 || bus.s_wstrb !== 4'h0) begin
      bad++; $display("FAIL sr_req: got v=%b a=%h s=%h want 1/1000/0", bus.s_valid, bus.s_addr, bus.s_wstrb);
    end
    total++; if (bus.m_ready !== 3'b010 || bus.m_rdata !== 32'h1234_5678) begin
      bad++; $display("FAIL sr_resp: got r=%b d=%h want 010/12345678", bus.m_ready, bus.m_rdata);
    end
    tick();
    bus.m_valid = '0; bus.s_ready = 1'b0;
    exp_ptr = 2;
  endtask

  task automatic test_fair();
    int w;
    for (int i = 0; i < int'(NM); i++) begin
      bus.m_addr[i]  = 32'h100 * (i + 1);
      bus.m_wdata[i] = $urandom;
      bus.m_wstrb[i] = 4'(i + 1);
    end
    bus.m_valid = '1;
    for (int n = 0; n < 6; n++) begin
      w = rr_winner(bus.m_valid, exp_ptr);
      tick();
      bus.s_ready = 1'b1; bus.s_rdata = $urandom;
      #1;
      total++; if (bus.s_addr !== bus.m_addr[w] || bus.s_wdata !== bus.m_wdata[w] || bus.s_wstrb !== bus.m_wstrb[w]) begin
        bad++; $display("FAIL fair_req%0d: got a=%h d=%h s=%h want master %0d", n, bus.s_addr, bus.s_wdata, bus.s_wstrb, w);
      end
      total++; if (bus.m_ready !== onehot(w)) begin
        bad++; $display("FAIL fair_ready%0d: got %b want %b", n, bus.m_ready, onehot(w));
      end
      tick();
      bus.s_ready = 1'b0;
      exp_ptr = (w + 1) % int'(NM);
      #1;
      total++; if (bus.s_valid !== 1'b0 || bus.m_ready !== '0) begin
        bad++; $display("FAIL fair_gap%0d: got v=%b r=%b want 0/0", n, bus.s_valid, bus.m_ready);
      end
    end
    bus.m_valid = '0;
  endtask

  task automatic test_timeout();
    int c;
    issue(2, 32'h2000, 4'hF);
    tick();
    total++; if (bus.s_valid !== 1'b1) begin bad++; $display("FAIL to_svalid: got %b want 1", bus.s_valid); end
    wait_ready(c);
    total++; if (c != int'(TO) + 1) begin bad++; $display("FAIL to_latency: got %0d want %0d", c, TO + 1); end
    total++; if (bus.m_ready !== 3'b100 || bus.m_rdata !== 32'hDEAD_BEEF || bus.s_valid !== 1'b0) begin
      bad++; $display("FAIL to_resp: got r=%b d=%h v=%b want 100/deadbeef/0", bus.m_ready, bus.m_rdata, bus.s_valid);
    end
    tick();
    bus.m_valid = '0;
    exp_ptr = 0;
    total++; if (tmo_flag !== 1'b1 || tmo_addr !== 32'h2000) begin
      bad++; $display("FAIL to_latch: got %b/%h want 1/2000", tmo_flag, tmo_addr);
    end
  endtask

  task automatic test_tmo_sticky();
    int c;
    issue(0, 32'h3000, 4'h0);
    tick(); wait_ready(c); tick();
    bus.m_valid = '0; exp_ptr = 1;
    total++; if (tmo_flag !== 1'b1 || tmo_addr !== 32'h2000) begin
      bad++; $display("FAIL tmo_keep: got %b/%h want 1/2000", tmo_flag, tmo_addr);
    end
    tmo_clr = 1'b1; tick(); tmo_clr = 1'b0;
    total++; if (tmo_flag !== 1'b0 || tmo_addr !== 32'h0) begin
      bad++; $display("FAIL tmo_clr: got %b/%h want 0/0", tmo_flag, tmo_addr);
    end
    issue(1, 32'h4000, 4'h3);
    tick(); wait_ready(c); tick();
    bus.m_valid = '0; exp_ptr = 2;
    total++; if (tmo_flag !== 1'b1 || tmo_addr !== 32'h4000) begin
      bad++; $display("FAIL tmo_first: got %b/%h want 1/4000", tmo_flag, tmo_addr);
    end
    issue(2, 32'h3000, 4'h1);
    tick(); wait_ready(c);
    tmo_clr = 1'b1;
    tick();
    tmo_clr = 1'b0; bus.m_valid = '0; exp_ptr = 0;
    total++; if (tmo_flag !== 1'b1 || tmo_addr !== 32'h3000) begin
      bad++; $display("FAIL tmo_clr_set: got %b/%h want 1/3000", tmo_flag, tmo_addr);
    end
  endtask

  task automatic test_drop();
    int w;
    issue(exp_ptr, 32'h5000, 4'h0);
    tick();
    bus.m_valid = '0;
    #1;
    total++; if (bus.s_valid !== 1'b0 || bus.m_ready !== '0) begin
      bad++; $display("FAIL drop_busy: got v=%b r=%b want 0/0", bus.s_valid, bus.m_ready);
    end
    tick();
    bus.s_ready = 1'b1; bus.s_rdata = $urandom;
    #1;
    total++; if (bus.m_ready !== '0 || bus.m_rdata !== 32'h0) begin
      bad++; $display("FAIL drop_late: got r=%b d=%h want 0/0", bus.m_ready, bus.m_rdata);
    end
    tick();
    bus.s_ready = 1'b0;
    for (int i = 0; i < int'(NM); i++) bus.m_addr[i] = 32'h6000 + 32'(i);
    bus.m_valid = '1;
    w = rr_winner(bus.m_valid, exp_ptr);
    tick();
    bus.s_ready = 1'b1;
    #1;
    total++; if (bus.s_addr !== bus.m_addr[w] || bus.m_ready !== onehot(w)) begin
      bad++; $display("FAIL drop_ptr: got a=%h r=%b want %h/%b", bus.s_addr, bus.m_ready, bus.m_addr[w], onehot(w));
    end
    tick();
    bus.s_ready = 1'b0; bus.m_valid = '0;
    exp_ptr = (w + 1) % int'(NM);
  endtask

  task automatic test_reset_mid();
    int w;
    issue(2, 32'h7000, 4'hF);
    tick();
    bus.s_ready = 1'b1;
    #1;
    total++; if (bus.s_valid !== 1'b1 || bus.m_ready !== 3'b100) begin
      bad++; $display("FAIL rm_pre: got v=%b r=%b want 1/100", bus.s_valid, bus.m_ready);
    end
    #1 rst = 1'b1;
    #1;
    total++; if (bus.s_valid !== 1'b0 || bus.m_ready !== '0 || tmo_flag !== 1'b0) begin
      bad++; $display("FAIL rm_async: got v=%b r=%b f=%b want 0/0/0", bus.s_valid, bus.m_ready, tmo_flag);
    end
    tick();
    bus.s_ready = 1'b0; rst = 1'b0;
    exp_ptr = 0;
    bus.m_valid = '1;
    w = rr_winner(bus.m_valid, exp_ptr);
    tick();
    bus.s_ready = 1'b1;
    #1;
    total++; if (bus.m_ready !== onehot(w) || bus.s_addr !== bus.m_addr[w]) begin
      bad++; $display("FAIL rm_regrant: got r=%b a=%h want %b/%h", bus.m_ready, bus.s_addr, onehot(w), bus.m_addr[w]);
    end
    tick();
    bus.s_ready = 1'b0; bus.m_valid = '0;
    exp_ptr = (w + 1) % int'(NM);
  endtask

  task automatic test_random();
    logic [NM-1:0] pend;
    int            age [NM];
    int            max_age;
    int            w, k;
    logic [31:0]   rd;
    pend = '0; max_age = 0;
    for (int i = 0; i < int'(NM); i++) age[i] = 0;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < int'(NM); i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1; age[i] = 0;
          bus.m_addr[i]  = $urandom;
          bus.m_wdata[i] = $urandom;
          bus.m_wstrb[i] = 4'($urandom_range(0, 15));
        end
      end
      if (pend == '0) begin
        w = int'($urandom_range(0, NM - 1));
        pend[w] = 1'b1; age[w] = 0;
        bus.m_addr[w] = $urandom; bus.m_wdata[w] = $urandom; bus.m_wstrb[w] = 4'h0;
      end
      bus.m_valid = pend;
      w = rr_winner(pend, exp_ptr);
      k = int'($urandom_range(0, 3));
      tick();
      for (int j = 0; j < k; j++) begin
        #1;
        total++; if (bus.s_valid !== 1'b1 || bus.m_ready !== '0 || bus.s_addr !== bus.m_addr[w]) begin
          bad++; $display("FAIL rnd_wait%0d: got v=%b r=%b a=%h want 1/0/%h", n, bus.s_valid, bus.m_ready, bus.s_addr, bus.m_addr[w]);
        end
        tick();
      end
      rd = $urandom;
      bus.s_ready = 1'b1; bus.s_rdata = rd;
      #1;
      total++; if (bus.m_ready !== onehot(w) || bus.m_rdata !== rd || bus.s_addr !== bus.m_addr[w] ||
                   bus.s_wdata !== bus.m_wdata[w] || bus.s_wstrb !== bus.m_wstrb[w]) begin
        bad++; $display("FAIL rnd_txn%0d: got r=%b d=%h a=%h want r=%b d=%h a=%h", n, bus.m_ready, bus.m_rdata, bus.s_addr, onehot(w), rd, bus.m_addr[w]);
      end
      tick();
      bus.s_ready = 1'b0;
      pend[w] = 1'b0; bus.m_valid = pend;
      for (int i = 0; i < int'(NM); i++) begin
        if (pend[i]) begin
          age[i]++;
          if (age[i] > max_age) max_age = age[i];
        end
      end
      exp_ptr = (w + 1) % int'(NM);
    end
    bus.m_valid = '0;
    total++; if (max_age > int'(NM) - 1) begin bad++; $display("FAIL rnd_fair: got wait %0d want <= %0d", max_age, NM - 1); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fair();
    test_timeout();
    test_tmo_sticky();
    test_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
